subleq_exec_ctrl: RTL and testbench

Sequential SUBLEQ execution controller for the subleq machine. It fetches each three-byte instruction from a synchronous single-port memory, executes mem[B] = mem[B] − mem[A], and branches to C when the result is ≤ 0 (signed).
- It sits directly upstream of the register switch. Its eight architectural/debug registers drive the switch's eight 8-bit register ports (reg0–reg7), which the switch muxes onto its shared bus.

---
 rtl/subleq_exec_ctrl.sv | 167 ++++++++++++++++
 tb/tb_subleq_exec_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_exec_ctrl.sv
// subleq_exec_ctrl: multi-cycle SUBLEQ sequencer.
// Each instruction is three bytes {A, B, C}: mem[B] <= mem[B] - mem[A],
// then jump to C if the result is <= 0 (signed), otherwise fall through to
// pc+3. A branch to HALT_ADDR parks the machine in HALT until reset.
// Memory is a synchronous single-port RAM: rdata is valid one cycle after
// the address is presented, so every fetch state consumes the data
// requested by the previous state.
module subleq_exec_ctrl #(
  parameter int              DW        = 8,
  parameter logic [DW-1:0]   RESET_PC  = '0,
  // All-ones target (8'hFF at the default width) means "halt".
  parameter logic [DW-1:0]   HALT_ADDR = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [DW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          busy,
  output logic          halted,
  output logic [DW-1:0] reg0,
  output logic [DW-1:0] reg1,
  output logic [DW-1:0] reg2,
  output logic [DW-1:0] reg3,
  output logic [DW-1:0] reg4,
  output logic [DW-1:0] reg5,
  output logic [DW-1:0] reg6,
  output logic [DW-1:0] reg7
);

  // State encoding is visible in the status register, so it is fixed.
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_FA   = 4'd1;
  localparam logic [3:0] S_FB   = 4'd2;
  localparam logic [3:0] S_FC   = 4'd3;
  localparam logic [3:0] S_RA   = 4'd4;
  localparam logic [3:0] S_RB   = 4'd5;
  localparam logic [3:0] S_EX   = 4'd6;
  localparam logic [3:0] S_WR   = 4'd7;
  localparam logic [3:0] S_BR   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  // Address increments; the adders are DW bits wide so pc wraps naturally.
  localparam logic [DW-1:0] INC1 = DW'(1);
  localparam logic [DW-1:0] INC2 = DW'(2);
  localparam logic [DW-1:0] INC3 = DW'(3);

  logic [3:0]    state_reg, state_next;
  logic [DW-1:0] pc_reg;
  logic [DW-1:0] opa_reg;
  logic [DW-1:0] opb_reg;
  logic [DW-1:0] opc_reg;
  logic [DW-1:0] ma_reg;
  logic [DW-1:0] mb_reg;
  logic [DW-1:0] res_reg;
  logic          leq_reg;

  logic [DW-1:0] diff;
  logic          take_branch;
  logic          halt_branch;
  logic [7:0]    status;

  // Subtraction is plain modular arithmetic; only leq looks at the sign.
  assign diff        = mem_rdata - ma_reg;
  assign take_branch = leq_reg;
  assign halt_branch = leq_reg && (opc_reg == HALT_ADDR);

  // Next-state sequencing: a fixed walk FA..BR, with BR looping straight
  // back to FA (no IDLE gap) unless the branch target is the halt address.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  state_next = start ? S_FA : S_IDLE;
      S_FA:    state_next = S_FB;
      S_FB:    state_next = S_FC;
      S_FC:    state_next = S_RA;
      S_RA:    state_next = S_RB;
      S_RB:    state_next = S_EX;
      S_EX:    state_next = S_WR;
      S_WR:    state_next = S_BR;
      S_BR:    state_next = halt_branch ? S_HALT : S_FA;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Memory address select: each state presents the address whose data the
  // following state will capture.
  always_comb begin
    mem_addr = pc_reg;
    case (state_reg)
      S_FB:                mem_addr = pc_reg + INC1;
      S_FC:                mem_addr = pc_reg + INC2;
      S_RA:                mem_addr = opa_reg;
      S_RB, S_EX, S_WR:    mem_addr = opb_reg;
      default:             mem_addr = pc_reg;
    endcase
  end

  // The write strobe is masked by rst so a reset landing on WR never lets
  // the RAM commit a write on that same edge.
  assign mem_we    = (state_reg == S_WR) && !rst;
  assign mem_wdata = res_reg;

  // State register and datapath captures; reset wins over every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      opa_reg   <= '0;
      opb_reg   <= '0;
      opc_reg   <= '0;
      ma_reg    <= '0;
      mb_reg    <= '0;
      res_reg   <= '0;
      leq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_FB: opa_reg <= mem_rdata;
        S_FC: opb_reg <= mem_rdata;
        S_RA: opc_reg <= mem_rdata;
        S_RB: ma_reg  <= mem_rdata;
        S_EX: begin
          mb_reg  <= mem_rdata;
          res_reg <= diff;
        end
        S_WR: leq_reg <= res_reg[DW-1] | (res_reg == '0);
        S_BR: begin
          if (take_branch) begin
            // Halting leaves pc on the instruction that halted.
            if (!halt_branch) pc_reg <= opc_reg;
          end else begin
            pc_reg <= pc_reg + INC3;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign halted = (state_reg == S_HALT);
  assign status = {halted, busy, leq_reg, 1'b0, state_reg};

  assign reg0 = pc_reg;
  assign reg1 = opa_reg;
  assign reg2 = opb_reg;
  assign reg3 = opc_reg;
  assign reg4 = ma_reg;
  assign reg5 = mb_reg;
  assign reg6 = res_reg;

  // The status byte is 8 bits; fit it to the register port width.
  generate
    if (DW == 8) begin : g_status_eq
      assign reg7 = status;
    end else if (DW > 8) begin : g_status_wide
      assign reg7 = {{(DW-8){1'b0}}, status};
    end else begin : g_status_narrow
      assign reg7 = status[DW-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_subleq_exec_ctrl.sv
// Directed bench for subleq_exec_ctrl with a read-first synchronous RAM model.
module tb_subleq_exec_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       busy;
  logic       halted;
  logic [7:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;

  logic [7:0] mem [256];
  int         wr_count;
  int         checks;
  int         failures;

  subleq_exec_ctrl #(.DW(8), .RESET_PC(8'd0), .HALT_ADDR(8'hFF)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .busy(busy), .halted(halted),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read-first, data valid one cycle after the address.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_count = wr_count + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Steps from FA through BR (8 cycles), recording any write strobes.
  task automatic run_body(output logic [7:0] wa, output logic [7:0] wd, output int nwe);
    nwe = 0; wa = 8'h00; wd = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (mem_we) begin
        nwe++; wa = mem_addr; wd = mem_wdata;
      end
      step();
    end
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = 8'd16; mem[1] = 8'd17; mem[2] = 8'd3;
    do_reset();
    checks++; if (reg0 !== 8'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", reg0); end
    checks++; if ({reg1, reg2, reg3, reg4, reg5, reg6} !== 48'd0) begin failures++; $display("FAIL reset_regs got=%0h exp=0", {reg1, reg2, reg3, reg4, reg5, reg6}); end
    checks++; if (reg7 !== 8'h00) begin failures++; $display("FAIL reset_status got=%0h exp=00", reg7); end
    checks++; if ({busy, halted, mem_we} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, halted, mem_we}); end
    checks++; if (mem_addr !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    $display("test_reset done");
  endtask

  task automatic test_positive();
    int w0;
    int nwe;
    clear_mem();
    mem[0] = 8'd16; mem[1] = 8'd17; mem[2] = 8'd3;
    mem[16] = 8'd3; mem[17] = 8'd5;
    do_reset();
    pulse_start();
    w0 = wr_count;
    nwe = 0;
    for (int s = 1; s <= 8; s++) begin
      checks++; if (reg7[3:0] !== 4'(s)) begin failures++; $display("FAIL pos_state_walk got=%0d exp=%0d", reg7[3:0], s); end
      if (mem_we) nwe++;
      if (s == 7) begin
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd17, 8'd2}) begin failures++; $display("FAIL pos_write got=%b/%0d/%0d exp=1/17/2", mem_we, mem_addr, mem_wdata); end
      end
      step();
    end
    checks++; if (reg7[3:0] !== 4'd1) begin failures++; $display("FAIL pos_back_to_fa got=%0d exp=1", reg7[3:0]); end
    checks++; if (reg0 !== 8'd3) begin failures++; $display("FAIL pos_pc got=%0d exp=3", reg0); end
    checks++; if (nwe !== 1 || (wr_count - w0) !== 1) begin failures++; $display("FAIL pos_we_count got=%0d/%0d exp=1", nwe, wr_count - w0); end
    checks++; if (mem[17] !== 8'd2) begin failures++; $display("FAIL pos_mem17 got=%0d exp=2", mem[17]); end
    checks++; if ({reg1, reg2, reg3, reg4, reg5, reg6} !== {8'd16, 8'd17, 8'd3, 8'd3, 8'd5, 8'd2}) begin failures++; $display("FAIL pos_regs got=%0h exp=101103030502", {reg1, reg2, reg3, reg4, reg5, reg6}); end
    checks++; if (reg7[5] !== 1'b0) begin failures++; $display("FAIL pos_leq got=%b exp=0", reg7[5]); end
    $display("test_positive done");
  endtask

  task automatic test_leq_branch();
    logic [7:0] wa, wd;
    int nwe;
    logic [7:0] mb_vals [2];
    logic [7:0] exp_wd [2];
    mb_vals[0] = 8'd5; exp_wd[0] = 8'h00;
    mb_vals[1] = 8'd2; exp_wd[1] = 8'hFD;
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      mem[0] = 8'd16; mem[1] = 8'd17; mem[2] = 8'd40;
      mem[16] = 8'd5; mem[17] = mb_vals[t];
      do_reset();
      pulse_start();
      run_body(wa, wd, nwe);
      checks++; if ({nwe[7:0], wa, wd} !== {8'd1, 8'd17, exp_wd[t]}) begin failures++; $display("FAIL leq_write%0d got=%0d/%0d/%0h exp=1/17/%0h", t, nwe, wa, wd, exp_wd[t]); end
      checks++; if (reg7[5] !== 1'b1) begin failures++; $display("FAIL leq_flag%0d got=%b exp=1", t, reg7[5]); end
      checks++; if (reg0 !== 8'd40) begin failures++; $display("FAIL leq_pc%0d got=%0d exp=40", t, reg0); end
      checks++; if (mem[17] !== exp_wd[t]) begin failures++; $display("FAIL leq_mem%0d got=%0h exp=%0h", t, mem[17], exp_wd[t]); end
      $display("test_leq_branch case %0d done", t);
    end
  endtask

  task automatic test_halt();
    logic [7:0] wa, wd;
    int nwe;
    clear_mem();
    mem[0] = 8'd16; mem[1] = 8'd16; mem[2] = 8'hFF;
    mem[16] = 8'd7;
    do_reset();
    pulse_start();
    run_body(wa, wd, nwe);
    checks++; if (reg7 !== 8'b1010_1001) begin failures++; $display("FAIL halt_status got=%b exp=10101001", reg7); end
    checks++; if ({halted, busy} !== 2'b10) begin failures++; $display("FAIL halt_flags got=%b exp=10", {halted, busy}); end
    checks++; if (reg0 !== 8'd0) begin failures++; $display("FAIL halt_pc got=%0d exp=0", reg0); end
    checks++; if (mem[16] !== 8'd0) begin failures++; $display("FAIL halt_mem16 got=%0d exp=0", mem[16]); end
    pulse_start();
    step();
    checks++; if (reg7[3:0] !== 4'd9) begin failures++; $display("FAIL halt_sticky got=%0d exp=9", reg7[3:0]); end
    $display("test_halt done");
  endtask

  task automatic test_pc_wrap();
    logic [7:0] wa, wd;
    int nwe;
    clear_mem();
    // First instruction zeroes mem[16] and branches to 254.
    mem[0] = 8'd16; mem[1] = 8'd16; mem[2] = 8'd254;
    mem[254] = 8'd16; mem[255] = 8'd17;
    mem[16] = 8'd5; mem[17] = 8'd9;
    do_reset();
    pulse_start();
    run_body(wa, wd, nwe);
    checks++; if ({reg0, mem_addr} !== {8'd254, 8'd254}) begin failures++; $display("FAIL wrap_fa got=%0d/%0d exp=254/254", reg0, mem_addr); end
    step();
    checks++; if (mem_addr !== 8'd255) begin failures++; $display("FAIL wrap_fb_addr got=%0d exp=255", mem_addr); end
    step();
    checks++; if (mem_addr !== 8'd0) begin failures++; $display("FAIL wrap_fc_addr got=%0d exp=0", mem_addr); end
    for (int k = 0; k < 4; k++) step();
    checks++; if ({mem_we, mem_addr, mem_wdata, reg3} !== {1'b1, 8'd17, 8'd9, 8'd16}) begin failures++; $display("FAIL wrap_write got=%b/%0d/%0d/%0d exp=1/17/9/16", mem_we, mem_addr, mem_wdata, reg3); end
    step();
    step();
    checks++; if ({reg7[3:0], reg0} !== {4'd1, 8'd1}) begin failures++; $display("FAIL wrap_pc got=%0d/%0d exp=1/1", reg7[3:0], reg0); end
    $display("test_pc_wrap done");
  endtask

  task automatic test_reset_mid();
    int w0;
    clear_mem();
    mem[0] = 8'd16; mem[1] = 8'd17; mem[2] = 8'd3;
    mem[16] = 8'd3; mem[17] = 8'd5;
    do_reset();
    pulse_start();
    for (int k = 0; k < 6; k++) step();
    checks++; if (reg7[3:0] !== 4'd7) begin failures++; $display("FAIL mid_in_wr got=%0d exp=7", reg7[3:0]); end
    w0 = wr_count;
    rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL mid_we_masked got=%b exp=0", mem_we); end
    step();
    rst = 1'b0;
    checks++; if ({reg7, reg0, reg1, reg2, reg3, reg4, reg5, reg6} !== 64'd0) begin failures++; $display("FAIL mid_regs got=%0h exp=0", {reg7, reg0, reg1, reg2, reg3, reg4, reg5, reg6}); end
    checks++; if ((wr_count - w0) !== 0 || mem[17] !== 8'd5) begin failures++; $display("FAIL mid_no_write got=%0d/%0d exp=0/5", wr_count - w0, mem[17]); end
    // A start pulse while in FC must not restart the sequence.
    pulse_start();
    step();
    step();
    checks++; if (reg7[3:0] !== 4'd3) begin failures++; $display("FAIL fc_reach got=%0d exp=3", reg7[3:0]); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({reg7[3:0], reg1, reg2} !== {4'd4, 8'd16, 8'd17}) begin failures++; $display("FAIL fc_start_ignored got=%0d/%0d/%0d exp=4/16/17", reg7[3:0], reg1, reg2); end
    for (int k = 0; k < 5; k++) step();
    checks++; if ({reg7[3:0], reg0, mem[17]} !== {4'd1, 8'd3, 8'd2}) begin failures++; $display("FAIL fc_complete got=%0d/%0d/%0d exp=1/3/2", reg7[3:0], reg0, mem[17]); end
    $display("test_reset_mid done");
  endtask

  task automatic test_self_modify();
    logic [7:0] wa, wd;
    int nwe;
    clear_mem();
    // Instruction 0 rewrites the C byte of instruction 3 (21 -> 20).
    mem[0] = 8'd16; mem[1] = 8'd5; mem[2] = 8'd50;
    mem[3] = 8'd17; mem[4] = 8'd17; mem[5] = 8'd21;
    mem[16] = 8'd1; mem[17] = 8'd4;
    do_reset();
    pulse_start();
    run_body(wa, wd, nwe);
    checks++; if ({reg0, wa, wd} !== {8'd3, 8'd5, 8'd20}) begin failures++; $display("FAIL smc_first got=%0d/%0d/%0d exp=3/5/20", reg0, wa, wd); end
    run_body(wa, wd, nwe);
    checks++; if (reg3 !== 8'd20) begin failures++; $display("FAIL smc_opc got=%0d exp=20", reg3); end
    checks++; if ({reg0, reg6, reg7[5]} !== {8'd20, 8'd0, 1'b1}) begin failures++; $display("FAIL smc_branch got=%0d/%0d/%b exp=20/0/1", reg0, reg6, reg7[5]); end
    checks++; if ({wa, wd} !== {8'd17, 8'd0}) begin failures++; $display("FAIL smc_write got=%0d/%0d exp=17/0", wa, wd); end
    $display("test_self_modify done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    wr_count = 0;
    rst = 1'b1;
    start = 1'b0;
    clear_mem();
    step();
    test_reset();
    test_positive();
    test_leq_branch();
    test_halt();
    test_pc_wrap();
    test_reset_mid();
    test_self_modify();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
